sensor_supervisor_multi: RTL and testbench

SENSOR_SUPERVISOR_MULTI -- requirements
Module: sensor_supervisor_multi

---
 rtl/sensor_supervisor_multi.sv | 160 ++++++++++++++++
 tb/tb_sensor_supervisor_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_supervisor_multi.sv
// Multi-channel sensor supervisor: each channel trips its relay on a debounced
// out-of-band reading, holds it open for a wait period, and locks out after
// repeated trips until released by that channel's clear.
module sensor_supervisor_multi #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned W          = 16,
   parameter int unsigned SEN_REF    = 350,
   parameter int unsigned THRESHOLD  = 100,
   parameter int unsigned DEBOUNCE   = 3,
   parameter int unsigned WAIT_TICKS = 312,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic              clk_16ms,
   input  logic              rst,
   input  logic              enable,
   input  logic [N_CH-1:0]   clear,
   input  logic [N_CH*W-1:0] sen,
   output logic [N_CH-1:0]   relay_out,
   output logic [N_CH-1:0]   lockout,
   output logic              any_trip
);

   localparam int unsigned TW = $clog2(WAIT_TICKS + 1);
   localparam int unsigned DW = $clog2(DEBOUNCE + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 1);

   localparam logic [W-1:0]  REF_W     = W'(SEN_REF);
   localparam logic [W-1:0]  THR_W     = W'(THRESHOLD);
   localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TICKS - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StMonitor = 3'd1,
      StOpen    = 3'd2,
      StWait    = 3'd3,
      StLockout = 3'd4
   } state_e;

   for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
      logic [W-1:0]  sample;
      logic [W-1:0]  diff;
      logic          fail;
      logic          legal;
      state_e        state_q;
      logic [DW-1:0] deb_q;
      logic [TW-1:0] timer_q;
      logic [RW-1:0] retry_q;
      logic          relay_q;
      logic          lock_q;

      // Absolute deviation from nominal, larger minus smaller so it never wraps.
      always_comb begin
         sample = sen[k*W +: W];
         diff   = (sample > REF_W) ? (sample - REF_W) : (REF_W - sample);
         fail   = (diff > THR_W);
         legal  = state_q inside {StIdle, StMonitor, StOpen, StWait, StLockout};
      end

      // Channel FSM; relay/lockout are registered from the state being entered.
      always_ff @(posedge clk_16ms) begin
         if (rst) begin
            state_q <= StIdle;
            deb_q   <= '0;
            timer_q <= '0;
            retry_q <= '0;
            relay_q <= 1'b0;
            lock_q  <= 1'b0;
         end else if (state_q == StLockout && clear[k]) begin
            // Release works even while the global enable is low.
            state_q <= StIdle;
            deb_q   <= '0;
            timer_q <= '0;
            retry_q <= '0;
            relay_q <= 1'b0;
            lock_q  <= 1'b0;
         end else if (enable || !legal) begin
            case (state_q)
               StIdle: begin
                  deb_q   <= '0;
                  timer_q <= '0;
                  retry_q <= '0;
                  state_q <= StMonitor;
                  relay_q <= 1'b0;
                  lock_q  <= 1'b0;
               end
               StMonitor: begin
                  relay_q <= 1'b0;
                  lock_q  <= 1'b0;
                  if (fail) begin
                     timer_q <= '0;
                     if (deb_q == DEB_LAST) begin
                        deb_q   <= '0;
                        state_q <= StOpen;
                        relay_q <= 1'b1;
                     end else begin
                        deb_q <= deb_q + 1'b1;
                     end
                  end else begin
                     deb_q <= '0;
                     // A long enough healthy run forgives earlier trips.
                     if (retry_q != '0) begin
                        if (timer_q == WAIT_LAST) begin
                           retry_q <= '0;
                           timer_q <= '0;
                        end else begin
                           timer_q <= timer_q + 1'b1;
                        end
                     end
                  end
               end
               StOpen: begin
                  if (retry_q != RETRY_MAX) begin
                     retry_q <= retry_q + 1'b1;
                  end
                  timer_q <= '0;
                  state_q <= StWait;
                  relay_q <= 1'b1;
                  lock_q  <= 1'b0;
               end
               StWait: begin
                  relay_q <= 1'b1;
                  lock_q  <= 1'b0;
                  if (timer_q == WAIT_LAST) begin
                     timer_q <= '0;
                     if (retry_q == RETRY_MAX) begin
                        state_q <= StLockout;
                        lock_q  <= 1'b1;
                     end else begin
                        state_q <= StMonitor;
                        relay_q <= 1'b0;
                     end
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               StLockout: begin
                  relay_q <= 1'b1;
                  lock_q  <= 1'b1;
               end
               default: begin
                  state_q <= StIdle;
                  deb_q   <= '0;
                  timer_q <= '0;
                  retry_q <= '0;
                  relay_q <= 1'b0;
                  lock_q  <= 1'b0;
               end
            endcase
         end
      end

      assign relay_out[k] = relay_q;
      assign lockout[k]   = lock_q;
   end

   assign any_trip = |relay_out;

endmodule

// File: tb/tb_sensor_supervisor_multi.sv
// Bench for sensor_supervisor_multi: directed scenarios then random traffic,
// checked against a trip/hold/retry model of each channel.
module tb_sensor_supervisor_multi;

   localparam int N_CH       = 4;
   localparam int W          = 16;
   localparam int SEN_REF    = 350;
   localparam int THRESHOLD  = 100;
   localparam int DEBOUNCE   = 3;
   localparam int WAIT_TICKS = 312;
   localparam int MAX_RETRY  = 3;

   logic              clk_16ms = 1'b0;
   logic              rst      = 1'b1;
   logic              enable   = 1'b0;
   logic [N_CH-1:0]   clear    = '0;
   logic [N_CH*W-1:0] sen      = '0;
   logic [N_CH-1:0]   relay_out;
   logic [N_CH-1:0]   lockout;
   logic              any_trip;

   always #5 clk_16ms = ~clk_16ms;

   sensor_supervisor_multi #(
      .N_CH       (N_CH),
      .W          (W),
      .SEN_REF    (SEN_REF),
      .THRESHOLD  (THRESHOLD),
      .DEBOUNCE   (DEBOUNCE),
      .WAIT_TICKS (WAIT_TICKS),
      .MAX_RETRY  (MAX_RETRY)
   ) dut (
      .clk_16ms  (clk_16ms),
      .rst       (rst),
      .enable    (enable),
      .clear     (clear),
      .sen       (sen),
      .relay_out (relay_out),
      .lockout   (lockout),
      .any_trip  (any_trip)
   );

   typedef struct packed {
      logic [N_CH-1:0] relay;
      logic [N_CH-1:0] lock;
      logic            any;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Channel model: hold = enabled ticks the relay still stays open after a trip.
   int m_idle[N_CH];
   int m_locked[N_CH];
   int m_hold[N_CH];
   int m_fail_run[N_CH];
   int m_healthy[N_CH];
   int m_trips[N_CH];
   int chv[N_CH];

   task automatic fresh(input int k);
      m_idle[k]     = 1;
      m_locked[k]   = 0;
      m_hold[k]     = 0;
      m_fail_run[k] = 0;
      m_healthy[k]  = 0;
      m_trips[k]    = 0;
   endtask

   task automatic model_tick(input logic r, input logic e, input logic [N_CH-1:0] c,
                             input logic [N_CH*W-1:0] s);
      for (int k = 0; k < N_CH; k++) begin
         int v;
         int dev;
         bit fail;
         v    = int'(s[k*W +: W]);
         dev  = (v > SEN_REF) ? v - SEN_REF : SEN_REF - v;
         fail = dev > THRESHOLD;
         if (r) begin
            fresh(k);
         end else if (m_locked[k] != 0 && c[k]) begin
            fresh(k);
         end else if (!e || m_locked[k] != 0) begin
            // frozen or locked out
         end else if (m_idle[k] != 0) begin
            m_idle[k] = 0;
         end else if (m_hold[k] > 0) begin
            m_hold[k]--;
            if (m_hold[k] == 0 && m_trips[k] == MAX_RETRY) m_locked[k] = 1;
         end else if (fail) begin
            m_healthy[k] = 0;
            m_fail_run[k]++;
            if (m_fail_run[k] == DEBOUNCE) begin
               m_fail_run[k] = 0;
               if (m_trips[k] < MAX_RETRY) m_trips[k]++;
               m_hold[k] = WAIT_TICKS + 1;
            end
         end else begin
            m_fail_run[k] = 0;
            if (m_trips[k] > 0) begin
               m_healthy[k]++;
               if (m_healthy[k] == WAIT_TICKS) begin
                  m_trips[k]   = 0;
                  m_healthy[k] = 0;
               end
            end
         end
      end
   endtask

   function automatic logic [N_CH*W-1:0] pack_sen();
      logic [N_CH*W-1:0] p;
      for (int k = 0; k < N_CH; k++) p[k*W +: W] = W'(chv[k]);
      return p;
   endfunction

   // Drive one tick of inputs and queue what the outputs must be after the edge.
   task automatic step(input logic r, input logic e, input logic [N_CH-1:0] c);
      exp_t x;
      @(negedge clk_16ms);
      rst    = r;
      enable = e;
      clear  = c;
      sen    = pack_sen();
      model_tick(r, e, c, sen);
      for (int k = 0; k < N_CH; k++) begin
         x.relay[k] = (m_locked[k] != 0) || (m_hold[k] > 0);
         x.lock[k]  = (m_locked[k] != 0);
      end
      x.any = |x.relay;
      exp_q.push_back(x);
   endtask

   task automatic steps(input int n, input logic e, input logic [N_CH-1:0] c);
      for (int i = 0; i < n; i++) step(1'b0, e, c);
   endtask

   task automatic chk(input string name, input int k, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] at %0t: got=%b expected=%b", name, k, $time, act, exp);
      end
   endtask

   // Monitor: outputs are valid every tick; compare one queued entry per edge.
   initial begin
      forever begin
         @(posedge clk_16ms);
         #1;
         if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            for (int k = 0; k < N_CH; k++) begin
               chk("relay_out", k, relay_out[k], x.relay[k]);
               chk("lockout", k, lockout[k], x.lock[k]);
            end
            chk("any_trip", 0, any_trip, x.any);
         end
      end
   end

   initial begin
      int run_left[N_CH];
      logic [N_CH-1:0] c;
      for (int k = 0; k < N_CH; k++) begin
         fresh(k);
         chv[k]      = SEN_REF;
         run_left[k] = 0;
      end

      repeat (3) step(1'b1, 1'b1, '0);
      steps(5, 1'b1, '0);

      // Two failing ticks are not enough; three trip and hold for OPEN + WAIT.
      chv[1] = 451; steps(2, 1'b1, '0);
      chv[1] = 350; steps(10, 1'b1, '0);
      chv[1] = 451; steps(3, 1'b1, '0);
      chv[1] = 350; steps(330, 1'b1, '0);

      // Exact-threshold reading, persistent fault to lockout, single trip that decays.
      chv[0] = 450; chv[2] = 249; chv[3] = 451;
      steps(3, 1'b1, '0);
      chv[3] = 350;
      steps(100, 1'b1, '0);
      steps(50, 1'b0, '0);
      steps(1000, 1'b1, '0);

      // Channel 3 now forgiven: needs three fresh trips before lockout.
      chv[3] = 451;
      steps(700, 1'b1, '0);
      chv[3] = 350; steps(20, 1'b1, '0);
      chv[3] = 451; steps(400, 1'b1, '0);

      // Release channel 2 with enable low; clear on non-locked channels is ignored.
      chv[2] = 350;
      step(1'b0, 1'b0, 4'b0100);
      steps(2, 1'b0, '0);
      steps(3, 1'b1, '0);
      steps(5, 1'b1, 4'b0011);

      // Reset while channel 0 locks out and channel 1 sits in WAIT.
      chv[0] = 600; chv[3] = 350;
      steps(960, 1'b1, '0);
      chv[1] = 100; steps(50, 1'b1, '0);
      step(1'b1, 1'b1, '0);
      chv[0] = 350; chv[1] = 350;
      steps(10, 1'b1, '0);

      // Random traffic: runs of healthy, boundary and failing readings.
      for (int i = 0; i < 6000; i++) begin
         for (int k = 0; k < N_CH; k++) begin
            if (run_left[k] == 0) begin
               case ($urandom_range(0, 5))
                  0, 1: chv[k] = int'($urandom_range(250, 450));
                  2:    chv[k] = ($urandom_range(0, 1) != 0) ? 450 : 250;
                  3:    chv[k] = ($urandom_range(0, 1) != 0) ? 451 : 249;
                  default: chv[k] = int'($urandom_range(0, 65535));
               endcase
               run_left[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 600))
                                                        : int'($urandom_range(1, 8));
            end
            run_left[k]--;
         end
         for (int k = 0; k < N_CH; k++) c[k] = ($urandom_range(0, 29) == 0);
         step($urandom_range(0, 1999) == 0, $urandom_range(0, 19) != 0, c);
      end

      repeat (3) @(posedge clk_16ms);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got=%0d pending expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
